fetch_decode: RTL and testbench

Front end of the core: owns the program counter, drives the instruction-ROM address, decodes one 16-bit Thumb-subset instruction per cycle, and issues registered decode fields to Execute. It consumes Execute's branch feedback (`global_disable`, `delta_instruction`) to redirect the PC and squash wrong-path instructions.

---
 rtl/fetch_decode_if.sv | 43 ++++
 rtl/fetch_decode.sv | 158 +++++++++++++++
 tb/tb_fetch_decode.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// ============================================================================
// Module   : fetch_decode_if
// Desc     : Fetch/decode bus: instruction-ROM port, branch feedback from
//            Execute and the decoded fields issued to Execute.
//            FETCH_DECODE_HALT_EN adds the halted status signal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_decode_if;
    logic [31:0] instr_addr;
    logic [15:0] instr_data;
    logic        global_disable;
    logic [31:0] delta_instruction;
    logic        num_to_rhs;
    logic [31:0] num;
    logic [3:0]  sel_p0;
    logic [3:0]  sel_p1;
    logic [3:0]  sel_in;
    logic [4:0]  uop;
    logic [3:0]  branch_cond;
`ifdef FETCH_DECODE_HALT_EN
    logic        halted;
`endif

    modport master (
        output instr_addr, num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond,
`ifdef FETCH_DECODE_HALT_EN
        output halted,
`endif
        input  instr_data, global_disable, delta_instruction
    );

    modport slave (
        input  instr_addr, num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond,
`ifdef FETCH_DECODE_HALT_EN
        input  halted,
`endif
        output instr_data, global_disable, delta_instruction
    );
endinterface

`default_nettype wire

// File: rtl/fetch_decode.sv
// ============================================================================
// Module   : fetch_decode
// Desc     : PC owner, ROM addressing and 16-bit Thumb-subset decode with
//            registered issue to Execute; redirects on taken branches.
//            FETCH_DECODE_HALT_EN enables UDF (0xDExx) halting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fetch_decode_if.master bus
);

    typedef struct packed {
        logic [4:0]  uop;
        logic        num_to_rhs;
        logic [31:0] num;
        logic [3:0]  sel_p0;
        logic [3:0]  sel_p1;
        logic [3:0]  sel_in;
        logic [3:0]  branch_cond;
    } dec_t;

    localparam logic [4:0] c_uop_nop = 5'd0;
    localparam logic [4:0] c_uop_mov = 5'd1;
    localparam logic [4:0] c_uop_add = 5'd2;
    localparam logic [4:0] c_uop_sub = 5'd3;
    localparam logic [4:0] c_uop_cmp = 5'd4;
    localparam logic [4:0] c_uop_and = 5'd5;
    localparam logic [4:0] c_uop_orr = 5'd6;
    localparam logic [4:0] c_uop_eor = 5'd7;
    localparam logic [4:0] c_uop_lsl = 5'd8;
    localparam logic [4:0] c_uop_lsr = 5'd9;
    localparam logic [4:0] c_uop_ldr = 5'd10;
    localparam logic [4:0] c_uop_str = 5'd11;
    localparam logic [4:0] c_uop_b   = 5'd12;
    localparam dec_t       c_nop     = '{uop: 5'd0, num_to_rhs: 1'b0, num: 32'd0, sel_p0: 4'd0,
                                         sel_p1: 4'd0, sel_in: 4'd0, branch_cond: 4'hF};

    logic [31:0] r_pc;
    logic        r_fetch_valid;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_branch_pc;
    dec_t        r_out;
    dec_t        w_dec;
    logic [31:0] w_redirect_sum;
    logic [15:0] w_ins;
`ifdef FETCH_DECODE_HALT_EN
    logic        r_halted;
    logic        w_is_udf;
`endif

    assign w_ins = bus.instr_data;

    always_comb begin
        w_dec = c_nop;
        if (w_ins[15:11] == 5'b00100) begin
            w_dec.uop = c_uop_mov;  w_dec.sel_in = {1'b0, w_ins[10:8]};
            w_dec.num = {24'd0, w_ins[7:0]};  w_dec.num_to_rhs = 1'b1;
        end else if (w_ins[15:12] == 4'b0011) begin
            w_dec.uop    = w_ins[11] ? c_uop_sub : c_uop_add;
            w_dec.sel_p1 = {1'b0, w_ins[10:8]};  w_dec.sel_in = {1'b0, w_ins[10:8]};
            w_dec.num    = {24'd0, w_ins[7:0]};  w_dec.num_to_rhs = 1'b1;
        end else if (w_ins[15:11] == 5'b00101) begin
            w_dec.uop = c_uop_cmp;  w_dec.sel_p1 = {1'b0, w_ins[10:8]};
            w_dec.num = {24'd0, w_ins[7:0]};  w_dec.num_to_rhs = 1'b1;
        end else if (w_ins[15:10] == 6'b000110) begin
            w_dec.uop    = w_ins[9] ? c_uop_sub : c_uop_add;
            w_dec.sel_p0 = {1'b0, w_ins[8:6]};
            w_dec.sel_p1 = {1'b0, w_ins[5:3]};
            w_dec.sel_in = {1'b0, w_ins[2:0]};
        end else if (w_ins[15:10] == 6'b010000) begin
            // Unsupported ALU ops leave the whole field set at NOP
            case (w_ins[9:6])
                4'b0000: w_dec.uop = c_uop_and;
                4'b0001: w_dec.uop = c_uop_eor;
                4'b0010: w_dec.uop = c_uop_lsl;
                4'b0011: w_dec.uop = c_uop_lsr;
                4'b1100: w_dec.uop = c_uop_orr;
                4'b1010: w_dec.uop = c_uop_cmp;
                default: w_dec.uop = c_uop_nop;
            endcase
            if (w_dec.uop != c_uop_nop) begin
                w_dec.sel_p0 = {1'b0, w_ins[5:3]};
                w_dec.sel_p1 = {1'b0, w_ins[2:0]};
                w_dec.sel_in = {1'b0, w_ins[2:0]};
            end
        end else if (w_ins[15:12] == 4'b0110) begin
            w_dec.uop        = w_ins[11] ? c_uop_ldr : c_uop_str;
            w_dec.sel_p1     = {1'b0, w_ins[5:3]};
            w_dec.num        = {25'd0, w_ins[10:6], 2'b00};
            w_dec.num_to_rhs = 1'b1;
            if (w_ins[11]) w_dec.sel_in = {1'b0, w_ins[2:0]};
            else           w_dec.sel_p0 = {1'b0, w_ins[2:0]};
        end else if (w_ins[15:12] == 4'b1101 && w_ins[11:9] != 3'b111) begin
            // Condition 4'hE in this slot is UDF, never a conditional branch
            w_dec.uop = c_uop_b;  w_dec.branch_cond = w_ins[11:8];
            w_dec.num = {{24{w_ins[7]}}, w_ins[7:0]};
        end else if (w_ins[15:11] == 5'b11100) begin
            w_dec.uop = c_uop_b;  w_dec.branch_cond = 4'hE;
            w_dec.num = {{21{w_ins[10]}}, w_ins[10:0]};
        end
    end

    assign w_redirect_sum = r_branch_pc + 32'd4 + {bus.delta_instruction[30:0], 1'b0};

`ifdef FETCH_DECODE_HALT_EN
    assign w_is_udf   = (w_ins[15:8] == 8'hDE);
    assign bus.halted = r_halted;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_branch_pc   <= 32'd0;
            r_out         <= c_nop;
`ifdef FETCH_DECODE_HALT_EN
            r_halted      <= 1'b0;
`endif
        end else if (bus.global_disable) begin
            r_pc          <= {w_redirect_sum[31:1], 1'b0};
            r_fetch_valid <= 1'b0;
            r_out         <= c_nop;
`ifdef FETCH_DECODE_HALT_EN
            r_halted      <= 1'b0;
        end else if (r_halted) begin
            r_out         <= c_nop;
`endif
        end else begin
            r_pc          <= r_pc + 32'd2;
            r_fetch_valid <= 1'b1;
            r_fetch_pc    <= r_pc;
            r_out         <= r_fetch_valid ? w_dec : c_nop;
            if (r_fetch_valid && w_dec.uop == c_uop_b) r_branch_pc <= r_fetch_pc;
`ifdef FETCH_DECODE_HALT_EN
            if (r_fetch_valid && w_is_udf) r_halted <= 1'b1;
`endif
        end
    end

    assign bus.instr_addr  = r_pc;
    assign bus.uop         = r_out.uop;
    assign bus.num_to_rhs  = r_out.num_to_rhs;
    assign bus.num         = r_out.num;
    assign bus.sel_p0      = r_out.sel_p0;
    assign bus.sel_p1      = r_out.sel_p1;
    assign bus.sel_in      = r_out.sel_in;
    assign bus.branch_cond = r_out.branch_cond;

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode.sv
// ============================================================================
// Module   : tb_fetch_decode
// Desc     : Directed bench for fetch_decode with a one-cycle-latency ROM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_decode;
    logic        clk;
    logic        rst;
    logic [15:0] rom [0:63];
    int          n_checks;
    int          n_fail;

    fetch_decode_if bus ();

    fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.instr_data <= rom[bus.instr_addr[6:1]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_dec(input string tag, input logic [4:0] uop, input logic rhs,
                             input logic [31:0] num, input logic [3:0] p0, input logic [3:0] p1,
                             input logic [3:0] sin, input logic [3:0] cond);
        check({tag, ".uop"},  {27'd0, bus.uop}, {27'd0, uop});
        check({tag, ".rhs"},  {31'd0, bus.num_to_rhs}, {31'd0, rhs});
        check({tag, ".num"},  bus.num, num);
        check({tag, ".p0"},   {28'd0, bus.sel_p0}, {28'd0, p0});
        check({tag, ".p1"},   {28'd0, bus.sel_p1}, {28'd0, p1});
        check({tag, ".in"},   {28'd0, bus.sel_in}, {28'd0, sin});
        check({tag, ".cond"}, {28'd0, bus.branch_cond}, {28'd0, cond});
    endtask

    task automatic check_nop(input string tag);
        check_dec(tag, 5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hF);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        rom[0]  = 16'h2105;  // MOV r1,#5
        rom[1]  = 16'h1888;  // ADD r0,r1,r2
        rom[2]  = 16'hD0FE;  // BEQ -2 (not taken)
        rom[3]  = 16'h3203;  // ADD r2,#3
        rom[4]  = 16'h4048;  // EOR r0,r1
        rom[5]  = 16'h6848;  // LDR r0,[r1,#4]
        rom[6]  = 16'h6011;  // STR r1,[r2,#0]
        rom[7]  = 16'h43C0;  // unsupported ALU op
        rom[8]  = 16'hE003;  // B +3 at 0x10
        rom[9]  = 16'h2007;  // wrong path
        rom[10] = 16'hE7FF;  // wrong-path B
        rom[11] = 16'h2008;
        rom[12] = 16'h2009;
        rom[13] = 16'h2A1B;  // CMP r2,#0x1B at 0x1A
        rom[14] = 16'hDE00;  // UDF
        rom[15] = 16'h2001;  // MOV r0,#1

        rst = 1'b1;
        bus.global_disable    = 1'b0;
        bus.delta_instruction = 32'd0;
        step(); step(); step();
        check("reset.addr", bus.instr_addr, 32'h0);
        check_nop("reset");
`ifdef FETCH_DECODE_HALT_EN
        check("reset.halted", {31'd0, bus.halted}, 32'd0);
`endif
        rst = 1'b0;

        step();
        check("e1.addr", bus.instr_addr, 32'h2);
        check_nop("e1");
        step();
        check("e2.addr", bus.instr_addr, 32'h4);
        check_dec("mov", 5'd1, 1'b1, 32'd5, 4'd0, 4'd0, 4'd1, 4'hF);
        step();
        check_dec("add_reg", 5'd2, 1'b0, 32'd0, 4'd2, 4'd1, 4'd0, 4'hF);
        step();
        check("beq.addr", bus.instr_addr, 32'h8);
        check_dec("beq", 5'd12, 1'b0, 32'hFFFF_FFFE, 4'd0, 4'd0, 4'd0, 4'h0);
        step();
        check("beq.nobubble.addr", bus.instr_addr, 32'hA);
        check_dec("add_imm", 5'd2, 1'b1, 32'd3, 4'd0, 4'd2, 4'd2, 4'hF);
        step();
        check_dec("eor", 5'd7, 1'b0, 32'd0, 4'd1, 4'd0, 4'd0, 4'hF);
        step();
        check_dec("ldr", 5'd10, 1'b1, 32'd4, 4'd0, 4'd1, 4'd0, 4'hF);
        step();
        check_dec("str", 5'd11, 1'b1, 32'd0, 4'd1, 4'd2, 4'd0, 4'hF);
        step();
        check_nop("bad_alu");
        step();
        check("b.addr", bus.instr_addr, 32'h14);
        check_dec("b", 5'd12, 1'b0, 32'd3, 4'd0, 4'd0, 4'd0, 4'hE);

        bus.global_disable    = 1'b1;
        bus.delta_instruction = 32'd3;
        step();
        bus.global_disable    = 1'b0;
        bus.delta_instruction = 32'd0;
        check("redir.addr", bus.instr_addr, 32'h1A);
        check_nop("bubble1");
        step();
        check("redir1.addr", bus.instr_addr, 32'h1C);
        check_nop("bubble2");
        step();
        check("target.addr", bus.instr_addr, 32'h1E);
        check_dec("target_cmp", 5'd4, 1'b1, 32'h1B, 4'd0, 4'd2, 4'd0, 4'hF);
        step();
        check("udf.addr", bus.instr_addr, 32'h20);
        check_nop("udf");
`ifdef FETCH_DECODE_HALT_EN
        check("udf.halted", {31'd0, bus.halted}, 32'd1);
        step();
        check("halt1.addr", bus.instr_addr, 32'h20);
        check_nop("halt1");
        step();
        check("halt2.addr", bus.instr_addr, 32'h20);
        check_nop("halt2");
        check("halt2.halted", {31'd0, bus.halted}, 32'd1);
`else
        step();
        check("post_udf.addr", bus.instr_addr, 32'h22);
        check_dec("post_udf", 5'd1, 1'b1, 32'd1, 4'd0, 4'd0, 4'd0, 4'hF);
`endif

        // Reset coincident with a redirect must win and discard the target
        rst = 1'b1;
        bus.global_disable    = 1'b1;
        bus.delta_instruction = 32'd5;
        step();
        check("rst_redir.addr", bus.instr_addr, 32'h0);
        check_nop("rst_redir");
`ifdef FETCH_DECODE_HALT_EN
        check("rst_redir.halted", {31'd0, bus.halted}, 32'd0);
`endif
        rst = 1'b0;
        bus.global_disable    = 1'b0;
        bus.delta_instruction = 32'd0;
        step();
        check("rst_release.addr", bus.instr_addr, 32'h2);

        // branch_pc is 0 after reset, so delta -3 lands on 0xFFFFFFFE
        bus.global_disable    = 1'b1;
        bus.delta_instruction = 32'hFFFF_FFFD;
        step();
        bus.global_disable    = 1'b0;
        bus.delta_instruction = 32'd0;
        check("neg_redir.addr", bus.instr_addr, 32'hFFFF_FFFE);
        step();
        check("wrap.addr", bus.instr_addr, 32'h0);
        check_nop("wrap");
        step();
        check("wrap1.addr", bus.instr_addr, 32'h2);
        step();
        check("wrap2.addr", bus.instr_addr, 32'h4);
        check_dec("wrap_mov", 5'd1, 1'b1, 32'd5, 4'd0, 4'd0, 4'd1, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
